// File: rtl/inv_sbox_seq.sv
// inv_sbox_seq: row-serial AES InvSubBytes over a character matrix with start/valid/ack handshake.
// Optional INV_SBOX_ZERO_SKIP_EN: PROC visits only rows whose mask bit is set.
module inv_sbox_seq #(
   parameter int ROWS   = 16,
   parameter int COLS   = 16,
   parameter int CHAR_W = 16
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   inv_sbox_ip_start,
   input  logic [ROWS-1:0][COLS-1:0][CHAR_W-1:0]  inv_sbox_ip_char_matrix,
   input  logic [ROWS-1:0]                        inv_sbox_ip_char_row_mask,
   input  logic                                   inv_sbox_op_ack,
   output logic                                   inv_sbox_op_busy,
   output logic                                   inv_sbox_op_char_matrix_valid,
   output logic [ROWS-1:0][COLS-1:0][CHAR_W-1:0]  inv_sbox_op_char_matrix
);
   localparam int PW = $clog2(ROWS) + 1;

   typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

   state_t                                 state_q, state_d;
   logic [PW-1:0]                          ptr_q, ptr_d, next_ptr, first_ptr;
   logic [ROWS-1:0]                        mask_q, mask_d;
   logic [ROWS-1:0][COLS-1:0][CHAR_W-1:0]  mat_q, mat_d;
   logic [COLS-1:0][CHAR_W-1:0]            sub_row;
   logic [PW-2:0]                          row_idx;
   logic                                   last_row;

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      logic [0:15][7:0] r;
      case (x[7:4])
         4'h0: r = 128'h52096ad53036a538bf40a39e81f3d7fb;
         4'h1: r = 128'h7ce339829b2fff87348e4344c4dee9cb;
         4'h2: r = 128'h547b9432a6c2233dee4c950b42fac34e;
         4'h3: r = 128'h082ea16628d924b2765ba2496d8bd125;
         4'h4: r = 128'h72f8f66486689816d4a45ccc5d65b692;
         4'h5: r = 128'h6c704850fdedb9da5e154657a78d9d84;
         4'h6: r = 128'h90d8ab008cbcd30af7e45805b8b34506;
         4'h7: r = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
         4'h8: r = 128'h3a9111414f67dcea97f2cfcef0b4e673;
         4'h9: r = 128'h96ac7422e7ad3585e2f937e81c75df6e;
         4'ha: r = 128'h47f11a711d29c5896fb7620eaa18be1b;
         4'hb: r = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
         4'hc: r = 128'h1fdda8338807c731b11210592780ec5f;
         4'hd: r = 128'h60517fa919b54a0d2de57a9f93c99cef;
         4'he: r = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
         default: r = 128'h172b047eba77d626e169146355210c7d;
      endcase
      return r[x[3:0]];
   endfunction

   assign row_idx = ptr_q[PW-2:0];

   for (genvar c = 0; c < COLS; c++) begin : g_col
      assign sub_row[c] = {mat_q[row_idx][c][CHAR_W-1:8], inv_sbox(mat_q[row_idx][c][7:0])};
   end

`ifdef INV_SBOX_ZERO_SKIP_EN
   // Descending scan leaves the lowest qualifying index as the winner.
   always_comb begin
      next_ptr  = PW'(ROWS);
      first_ptr = '0;
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (mask_q[i] && PW'(i) > ptr_q) next_ptr = PW'(i);
         if (inv_sbox_ip_char_row_mask[i]) first_ptr = PW'(i);
      end
   end
   assign last_row = next_ptr == PW'(ROWS);
`else
   assign next_ptr  = ptr_q + PW'(1);
   assign first_ptr = '0;
   assign last_row  = ptr_q == PW'(ROWS - 1);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         mask_q  <= '0;
         mat_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         mask_q  <= mask_d;
         mat_q   <= mat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = inv_sbox_ip_start ? PROC : IDLE;
         PROC:    state_d = last_row ? DONE : PROC;
         DONE:    state_d = inv_sbox_op_ack ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mat_d  = mat_q;
      mask_d = mask_q;
      ptr_d  = ptr_q;
      if (state_q == IDLE && inv_sbox_ip_start) begin
         mat_d  = inv_sbox_ip_char_matrix;
         mask_d = inv_sbox_ip_char_row_mask;
         ptr_d  = first_ptr;
      end else if (state_q == PROC) begin
         if (mask_q[row_idx]) mat_d[row_idx] = sub_row;
         ptr_d = next_ptr;
      end
   end

   always_comb begin
      inv_sbox_op_busy              = state_q != IDLE;
      inv_sbox_op_char_matrix_valid = state_q == DONE;
      inv_sbox_op_char_matrix       = mat_q;
   end
endmodule

// File: tb/tb_inv_sbox_seq.sv
// tb_inv_sbox_seq: directed scoreboard bench for inv_sbox_seq; honours INV_SBOX_ZERO_SKIP_EN.
module tb_inv_sbox_seq;
   localparam int R = 16, C = 16, W = 16;
   typedef logic [R-1:0][C-1:0][W-1:0] mat_t;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

`ifdef INV_SBOX_ZERO_SKIP_EN
   localparam int LAT_ONE = 2, LAT_TWO = 3, LAT_NONE = 2;
`else
   localparam int LAT_ONE = 17, LAT_TWO = 17, LAT_NONE = 17;
`endif

   logic clk = 1'b0, reset, start, ack, busy, valid, valid_d = 1'b0;
   logic [R-1:0] mask;
   mat_t din, dout, mon_e, d, e;
   int vectors = 0, miscompares = 0;
   mat_t exp_q[$];

   always #5 clk = ~clk;

   inv_sbox_seq dut (
      .clk                           (clk),
      .reset                         (reset),
      .inv_sbox_ip_start             (start),
      .inv_sbox_ip_char_matrix       (din),
      .inv_sbox_ip_char_row_mask     (mask),
      .inv_sbox_op_ack               (ack),
      .inv_sbox_op_busy              (busy),
      .inv_sbox_op_char_matrix_valid (valid),
      .inv_sbox_op_char_matrix       (dout)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_mat(input string name, input mat_t ex);
      vectors++;
      for (int i = 0; i < R; i++)
         for (int j = 0; j < C; j++)
            if (dout[i][j] !== ex[i][j]) begin
               miscompares++;
               $display("FAIL %s [%0d][%0d]: got %h expected %h", name, i, j, dout[i][j], ex[i][j]);
               return;
            end
   endtask

   // Monitor: every rising valid consumes one expected matrix.
   always @(negedge clk) begin
      if (valid && !valid_d) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_valid: got valid with empty scoreboard");
         end else begin
            mon_e = exp_q.pop_front();
            chk_mat("result_matrix", mon_e);
         end
      end
      valid_d <= valid;
   end

   task automatic run(input logic [R-1:0] m, input mat_t di, input mat_t ex, input int lat, input string name);
      int n;
      exp_q.push_back(ex);
      mask  = m;
      din   = di;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      din  = {R*C{16'hFFFF}};
      mask = '0;
      n = 1;
      while (!valid && n < 100) begin
         @(posedge clk);
         #1 n++;
      end
      chk({name, "_latency"}, n, lat);
   endtask

   task automatic do_ack();
      ack = 1'b1;
      @(posedge clk);
      #1 ack = 1'b0;
      chk("ack_valid_low", valid, 0);
      chk("ack_busy_low", busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start = 1'b0; ack = 1'b0; mask = '0; din = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("reset_valid", valid, 0);
      chk("reset_busy", busy, 0);
      chk_mat("reset_matrix", '0);

      d = {R*C{16'h0063}};
      d[0][1] = 16'h007C; d[5][3] = 16'h00FF; d[15][15] = 16'h0000;
      e = '0;
      e[0][1] = 16'h0001; e[5][3] = 16'h007D; e[15][15] = 16'h0052;
      run(16'hFFFF, d, e, 17, "full");
      do_ack();

      d = '0;
      d[0][0] = 16'hAB01; d[1][0] = 16'h0063;
      e = d;
      for (int j = 0; j < C; j++) e[0][j] = 16'h0052;
      e[0][0] = 16'hAB09;
      run(16'h0001, d, e, LAT_ONE, "upper");
      do_ack();

      d = {R*C{16'h0063}};
      d[0][1] = 16'h007C; d[5][3] = 16'h00FF; d[15][15] = 16'h0000;
      e = '0;
      e[0][1] = 16'h0001; e[5][3] = 16'h007D; e[15][15] = 16'h0052;
      run(16'hFFFF, d, e, 17, "hold");
      for (int k = 0; k < 20; k++) begin
         start = (k == 10);
         mask  = 16'h00FF;
         din   = {R*C{16'h1111}};
         @(posedge clk);
         #1 chk("hold_valid", valid, 1);
         chk_mat("hold_matrix", e);
      end
      start = 1'b0;
      do_ack();
      repeat (3) @(posedge clk);
      #1 chk("start_in_done_ignored", busy, 0);

      for (int i = 0; i < R; i++)
         for (int j = 0; j < C; j++) begin
            d[i][j] = {8'h00, SBOX[10*i+j]};
            e[i][j] = 16'(10*i+j);
         end
      run(16'hFFFF, d, e, 17, "round_trip");
      do_ack();

      d = {R*C{16'h1234}};
      e = d;
      for (int j = 0; j < C; j++) begin
         e[0][j]  = 16'h1228;
         e[15][j] = 16'h1228;
      end
      run(16'h8001, d, e, LAT_TWO, "mask_8001");
      do_ack();

      d[3][7] = 16'h00AA;
      run(16'h0000, d, d, LAT_NONE, "mask_zero");
      do_ack();

      mask = 16'hFFFF; din = {R*C{16'h0063}}; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      ack = 1'b1;
      repeat (5) @(posedge clk);
      #1 ack = 1'b0;
      chk("ack_in_proc_ignored", busy, 1);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("midreset_valid", valid, 0);
      chk("midreset_busy", busy, 0);
      chk_mat("midreset_matrix", '0);

      d = '0;
      d[0][0] = 16'hAB01; d[1][0] = 16'h0063;
      e = d;
      for (int j = 0; j < C; j++) e[0][j] = 16'h0052;
      e[0][0] = 16'hAB09;
      run(16'h0001, d, e, LAT_ONE, "after_reset");
      do_ack();

      repeat (3) @(posedge clk);
      #1 chk("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
